ram_program_loader: RTL

//  Writer-side front end for the CPU's 64x14 program/data RAM. Receives a framed byte

---
 rtl/ram_program_loader.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ram_program_loader.sv
// Byte-stream loader for the CPU program/data RAM: parses HDR, count, hi/lo word pairs and an
// XOR checksum, writes each word from address 0 upward, and holds the CPU in reset until a good frame lands.
module ram_program_loader #(
  parameter int          ADDR_W = 6,
  parameter int          DATA_W = 14,
  parameter int          WORDS  = 64,
  parameter logic [7:0]  HDR    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_write,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int HI_W  = DATA_W - 8;
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_CNT, S_HI, S_LO, S_WR, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  wcnt;
  logic [CNT_W-1:0]  remaining;
  logic [HI_W-1:0]   hi_byte;
  logic [7:0]        chk;
  logic              xfer;

  assign xfer     = in_valid & in_ready;
  // Counter is one bit wider so it can hold N after the last word without wrapping.
  assign ram_addr = wcnt[ADDR_W-1:0];

  function automatic logic count_ok(input logic [7:0] b);
    return (b != 8'd0) && (int'(b) <= WORDS);
  endfunction

  function automatic logic hi_ok(input logic [7:0] b);
    return b[7:HI_W] == '0;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      ram_write <= 1'b0;
      ram_data  <= '0;
      wcnt      <= '0;
      remaining <= '0;
      hi_byte   <= '0;
      chk       <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      ram_write <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state    <= S_SYNC;
            in_ready <= 1'b1;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            wcnt     <= '0;
            chk      <= '0;
          end
        end
        S_SYNC: begin
          if (xfer && in_data == HDR) state <= S_CNT;
        end
        S_CNT: begin
          if (xfer) begin
            if (count_ok(in_data)) begin
              state     <= S_HI;
              remaining <= in_data[CNT_W-1:0];
            end else begin
              state    <= S_ERR;
              err      <= 1'b1;
              in_ready <= 1'b0;
            end
          end
        end
        S_HI: begin
          if (xfer) begin
            hi_byte <= in_data[HI_W-1:0];
            chk     <= chk ^ in_data;
            if (hi_ok(in_data)) begin
              state <= S_LO;
            end else begin
              state    <= S_ERR;
              err      <= 1'b1;
              in_ready <= 1'b0;
            end
          end
        end
        S_LO: begin
          if (xfer) begin
            chk       <= chk ^ in_data;
            ram_data  <= {hi_byte, in_data};
            ram_write <= 1'b1;
            in_ready  <= 1'b0;
            state     <= S_WR;
          end
        end
        S_WR: begin
          // Write strobe is high this cycle; advance to the next word slot.
          wcnt      <= wcnt + CNT_W'(1);
          remaining <= remaining - CNT_W'(1);
          in_ready  <= 1'b1;
          state     <= (remaining == CNT_W'(1)) ? S_CHK : S_HI;
        end
        S_CHK: begin
          if (xfer) begin
            in_ready <= 1'b0;
            if (in_data == chk) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
